// File: rtl/isa_pkg.sv
// ISA definitions shared by the instruction encoder and decoder: mnemonic
// enumeration, opcode fields, condition codes, instruction formats and FSM states.
package isa_pkg;

    typedef enum logic [4:0] {
        MN_WAIT = 5'd0,
        MN_J    = 5'd1,
        MN_JEQ  = 5'd2,
        MN_JNE  = 5'd3,
        MN_JGT  = 5'd4,
        MN_JLE  = 5'd5,
        MN_B    = 5'd6,
        MN_BEQ  = 5'd7,
        MN_BNE  = 5'd8,
        MN_BGT  = 5'd9,
        MN_BLE  = 5'd10,
        MN_LOAD = 5'd11,
        MN_STOR = 5'd12,
        MN_ADDI = 5'd13,
        MN_SUBI = 5'd14,
        MN_AND  = 5'd15,
        MN_OR   = 5'd16,
        MN_XOR  = 5'd17,
        MN_NOT  = 5'd18,
        MN_ADD  = 5'd19,
        MN_ADDU = 5'd20,
        MN_ADDC = 5'd21,
        MN_RSH  = 5'd22,
        MN_SUB  = 5'd23,
        MN_CMP  = 5'd24,
        // The shift group sits past the last accepted value, so the encoder rejects it.
        MN_ALSH = 5'd25,
        MN_ARSH = 5'd26,
        MN_LSH  = 5'd27
    } mnem_e;

    localparam logic [4:0] MNEM_LAST_LEGAL = 5'd24;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOT  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_RSH  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_ALSH = 8'h0C;
    localparam logic [7:0] OP_ARSH = 8'h0F;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_LOAD = 8'h85;
    localparam logic [7:0] OP_STOR = 8'h87;

    localparam logic [3:0] PFX_ADDI = 4'h5;
    localparam logic [3:0] PFX_SUBI = 4'h9;
    localparam logic [3:0] PFX_JMP  = 4'h4;
    localparam logic [3:0] PFX_BR   = 4'hC;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_J,
        FMT_B,
        FMT_W,
        FMT_X
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_FINISH
    } enc_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_MNEM = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;

    function automatic fmt_e mnem_fmt(input logic [4:0] m);
        fmt_e f;
        if (m > MNEM_LAST_LEGAL)
            f = FMT_X;
        else if (m == MN_WAIT)
            f = FMT_W;
        else if (m <= MN_JLE)
            f = FMT_J;
        else if (m <= MN_BLE)
            f = FMT_B;
        else if (m == MN_ADDI || m == MN_SUBI)
            f = FMT_I;
        else
            f = FMT_R;
        return f;
    endfunction

    // 8-bit opcode for register-register formats, LOAD/STOR included.
    function automatic logic [7:0] mnem_rop(input logic [4:0] m);
        logic [7:0] op;
        case (m)
            MN_AND:  op = OP_AND;
            MN_OR:   op = OP_OR;
            MN_XOR:  op = OP_XOR;
            MN_NOT:  op = OP_NOT;
            MN_ADD:  op = OP_ADD;
            MN_ADDU: op = OP_ADDU;
            MN_ADDC: op = OP_ADDC;
            MN_RSH:  op = OP_RSH;
            MN_SUB:  op = OP_SUB;
            MN_CMP:  op = OP_CMP;
            MN_ALSH: op = OP_ALSH;
            MN_ARSH: op = OP_ARSH;
            MN_LSH:  op = OP_LSH;
            MN_LOAD: op = OP_LOAD;
            MN_STOR: op = OP_STOR;
            default: op = 8'h00;
        endcase
        return op;
    endfunction

    function automatic logic [3:0] mnem_cond(input logic [4:0] m);
        logic [3:0] c;
        case (m)
            MN_JEQ, MN_BEQ: c = COND_EQ;
            MN_JNE, MN_BNE: c = COND_NE;
            MN_JGT, MN_BGT: c = COND_GT;
            MN_JLE, MN_BLE: c = COND_LE;
            default:        c = COND_AL;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] mnem_ipfx(input logic [4:0] m);
        return (m == MN_SUBI) ? PFX_SUBI : PFX_ADDI;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Record stream from the host and write port into instruction RAM.
// The encoder uses the slave view; the host/RAM side uses the master view.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [4:0]        mnem;
    logic [3:0]        rdst;
    logic [3:0]        rsrc;
    logic [7:0]        imm;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;

    modport slave (
        input  in_valid, in_last, mnem, rdst, rsrc, imm, mem_ack,
        output in_ready, mem_req, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_last, mnem, rdst, rsrc, imm, mem_ack,
        input  in_ready, mem_req, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: maps a mnemonic record onto the 16-bit raw word the
// decoder consumes, flagging mnemonics outside the accepted range.
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [3:0]  rdst,
    input  logic [3:0]  rsrc,
    input  logic [7:0]  imm,
    output logic [15:0] word,
    output logic        illegal
);

    fmt_e fmt;

    always_comb begin
        fmt     = mnem_fmt(mnem);
        word    = 16'h0000;
        illegal = 1'b0;
        case (fmt)
            FMT_R:   word = {mnem_rop(mnem), rdst, rsrc};
            FMT_I:   word = {mnem_ipfx(mnem), rdst, imm};
            FMT_J:   word = {PFX_JMP, mnem_cond(mnem), imm};
            FMT_B:   word = {PFX_BR, mnem_cond(mnem), imm};
            FMT_W:   word = 16'h0000;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Session FSM that accepts mnemonic records, packs them and writes the words
// sequentially into instruction RAM over a req/ack port.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    instr_encoder_if.slave      bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [ADDR_W:0]     word_count
);

    localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    enc_state_e        state;
    logic [ADDR_W-1:0] ptr;
    logic              last_q;
    logic [15:0]       pk_word;
    logic              pk_illegal;
    logic [ADDR_W:0]   cnt_next;

    instr_pack u_pack (
        .mnem    (bus.mnem),
        .rdst    (bus.rdst),
        .rsrc    (bus.rsrc),
        .imm     (bus.imm),
        .word    (pk_word),
        .illegal (pk_illegal)
    );

    assign cnt_next = word_count + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            last_q        <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 16'h0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            word_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ptr          <= base_addr;
                        word_count   <= '0;
                        err          <= 1'b0;
                        err_code     <= ERR_NONE;
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b1;
                        state        <= ST_ACCEPT;
                    end
                end

                ST_ACCEPT: begin
                    if (bus.in_valid && bus.in_ready) begin
                        if (pk_illegal) begin
                            // Illegal records are dropped; a last flag still closes the session.
                            err      <= 1'b1;
                            err_code <= ERR_MNEM;
                            if (bus.in_last) begin
                                bus.in_ready <= 1'b0;
                                done         <= 1'b1;
                                state        <= ST_FINISH;
                            end
                        end else begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_addr  <= ptr;
                            bus.mem_wdata <= pk_word;
                            last_q        <= bus.in_last;
                            bus.in_ready  <= 1'b0;
                            state         <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        word_count  <= cnt_next;
                        // Pointer saturates at the top of memory instead of wrapping.
                        if (ptr != PTR_MAX)
                            ptr <= ptr + 1'b1;
                        if (last_q) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else if (cnt_next == MAX_CNT || ptr == PTR_MAX) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVF;
                            done     <= 1'b1;
                            state    <= ST_FINISH;
                        end else begin
                            bus.in_ready <= 1'b1;
                            state        <= ST_ACCEPT;
                        end
                    end
                end

                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    bus.in_ready <= 1'b0;
                    bus.mem_req  <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the CPU's instruction decoder: accepts mnemonic-level instruction records (mnemonic select, rdst, rsrc, immediate, condition) over a valid/ready stream.
- Packs each record into the 16-bit raw instruction format the decoder consumes.
- Writes the packed words sequentially into instruction memory through a request/acknowledge port.
- Sits between the host/boot interface and instruction RAM; used for program loading and for generating decoder test stimulus.

Parameters:
- ADDR_W, 8, width of the instruction-memory address and of the write pointer.
- MAX_WORDS, 256, maximum words per load session; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that opens a load session; ignored unless the FSM is in IDLE.
- base_addr  input  ADDR_W  first write address, sampled on start.
- in_valid  input  1  record valid.
- in_ready  output  1  encoder can accept a record.
- in_last  input  1  record is the final one of the session.
- mnem  input  5  mnemonic select (enumeration in package).
- rdst  input  4  destination register.
- rsrc  input  4  source register.
- imm  input  8  immediate or displacement.
- mem_req  output  1  write request to instruction RAM.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  encoded instruction.
- mem_ack  input  1  RAM accepted the write; may stall indefinitely.
- busy  output  1  session active.
- done  output  1  one-cycle pulse at session end.
- err  output  1  sticky error; cleared by the next accepted start.
- err_code  output  2  error cause: 0 none, 1 illegal mnemonic, 2 address overflow.
- word_count  output  ADDR_W+1  words written in the current or most recent session.

Behaviour:
- Reset (async, reset_n low): state IDLE. in_ready=0, mem_req=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, err_code=0, word_count=0.
- FSM has four states: IDLE, ACCEPT, WRITE, FINISH.
- IDLE: on start, load ptr=base_addr, clear word_count, err and err_code, then go to ACCEPT.
- ACCEPT: in_ready=1 and busy=1. A handshake (in_valid & in_ready) registers the encoded word, ptr and the last flag, then goes to WRITE.
  - If mnem is illegal: set err and err_code=1, write nothing. Go to FINISH if in_last, otherwise stay in ACCEPT.
- WRITE: in_ready=0. mem_req held with stable addr and data until mem_ack.
  - On ack: word_count+1 and ptr+1.
  - Then go to FINISH if last, or if word_count reaches MAX_WORDS (the latter sets err_code=2 when not last); otherwise return to ACCEPT.
  - If ptr=2^ADDR_W−1 at ack and the record is not last: set err_code=2 and go to FINISH. The pointer never wraps.
- FINISH: done=1 for exactly one cycle, then IDLE. err and word_count hold.
- Latency: handshake at cycle N gives mem_req high at N+1. Best-case throughput is one word per 2 cycles.
- start while not in IDLE is ignored. in_last with an illegal mnemonic still ends the session.
- Encoding, MSB first:
  - R-type {op8, rdst, rsrc}, with op8: AND 01, OR 02, XOR 03, NOT 04, ADD 05, ADDU 06, ADDC 07, RSH 08, SUB 09, CMP 0B, ALSH 0C, ARSH 0F, LSH 84.
  - LOAD {85, rdst, rsrc}; STOR {87, rdst, rsrc}.
  - ADDI {4'h5, rdst, imm}; SUBI {4'h9, rdst, imm}.
  - J/JEQ/JNE/JGT/JLE {4'h4, cond, imm}, with cond E/0/1/6/7 respectively.
  - B/BEQ/BNE/BGT/BLE {4'hC, cond, imm}, with the same cond values.
  - WAIT 16'h0000.
  - rsrc is ignored for I/J/B formats; rdst/rsrc are ignored for WAIT.
- Enumeration values 0–24 are legal; 25–31 are illegal.

Decomposition:
- Shared package `isa_pkg`: mnemonic enumeration, 8-bit R/load/store opcodes, 4-bit I/jump/branch prefixes, condition codes (EQ 0, NE 1, GT 6, LE 7, AL E), format flag constants.
- The decoder is to be refactored onto the same package.
- One combinational sub-module, `instr_pack`, maps (mnem, rdst, rsrc, imm) to {word[15:0], illegal}.
- The FSM, pointer and counters stay in `instr_encoder`.

Test Plan:
- Reset mid-WRITE: assert reset_n=0 while mem_req=1 -> all outputs reach their reset values immediately; a start after release opens a clean session.
- start base_addr=0x10; send ADD r3,r4, then ADDI r2,#0x7F (last); ack the next cycle -> writes 0x10←0x0534 and 0x11←0x527F, done pulses once, word_count=2, err=0.
- Send JGT #0x20, then BLE #0xF0, then WAIT (last); hold mem_ack low for 5 cycles on the first write -> mem_req/addr/data stable throughout; words 0x4620, 0xC7F0, 0x0000; in_ready low while stalled.
- Send mnem=27 (not last), then SUB r1,r2 (last) -> err=1 with err_code=1; only 0x0912 is written; word_count=1.
- base_addr=0xFE; send 3 non-last records -> two writes at 0xFE and 0xFF, then err_code=2 and done; the third record is never accepted.
- start pulsed during ACCEPT -> ignored; base address and count unchanged.
